// File: rtl/conv_loop_sequencer_pkg.sv
// Shared types for the convolution loop sequencer: FSM states,
// index bundles, save tags and the padding-tap predicate.
package conv_loop_sequencer_pkg;

   localparam int BYTE = 8;

   typedef enum logic [1:0] {
      SEQ_IDLE  = 2'd0,
      SEQ_RUN   = 2'd1,
      SEQ_DRAIN = 2'd2,
      SEQ_DONE  = 2'd3
   } seq_state_t;

   typedef struct packed {
      logic [BYTE-1:0] i;
      logic [BYTE-1:0] j;
      logic [BYTE-1:0] k;
      logic [BYTE-1:0] m;
      logic [BYTE-1:0] n;
      logic [BYTE-1:0] l;
   } loop_idx_t;

   typedef struct packed {
      logic [BYTE-1:0] i;
      logic [BYTE-1:0] j;
      logic [BYTE-1:0] k;
   } save_tag_t;

   // Input-plane coordinate of a tap, in 11-bit signed;
   // anything outside [0, dim_img) reads the zero border.
   function automatic logic tap_in_pad(
      input logic [BYTE-1:0] j,
      input logic [BYTE-1:0] k,
      input logic [BYTE-1:0] m,
      input logic [BYTE-1:0] n,
      input int              stride,
      input int              padding,
      input int              dim_img
   );
      logic signed [10:0] row;
      logic signed [10:0] col;
      logic signed [10:0] lim;
      row = 11'(stride * int'(j) + int'(m) - padding);
      col = 11'(stride * int'(k) + int'(n) - padding);
      lim = 11'(dim_img);
      return (row < 0) || (row >= lim) ||
             (col < 0) || (col >= lim);
   endfunction

endpackage

// File: rtl/conv_loop_sequencer_save_delay_line.sv
// Fixed-depth valid/payload shift register with sync reset.
// Ports: clk, reset, in_valid/in_data -> out_valid/out_data.
module save_delay_line #(
   parameter int DEPTH = 2,
   parameter int WIDTH = 24
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data
);

   logic [DEPTH-1:0] vld_q;
   logic [WIDTH-1:0] dat_q [DEPTH];

   // Payload only moves with a valid bit, so the head keeps
   // the most recent valid payload while bubbles pass through.
   always_ff @(posedge clk) begin
      if (reset) begin
         vld_q <= '0;
         for (int s = 0; s < DEPTH; s++) begin
            dat_q[s] <= '0;
         end
      end else begin
         vld_q[0] <= in_valid;
         if (in_valid) begin
            dat_q[0] <= in_data;
         end
         for (int s = 1; s < DEPTH; s++) begin
            vld_q[s] <= vld_q[s-1];
            if (vld_q[s-1]) begin
               dat_q[s] <= dat_q[s-1];
            end
         end
      end
   end

   assign out_valid = vld_q[DEPTH-1];
   assign out_data  = dat_q[DEPTH-1];

endmodule

// File: rtl/conv_loop_sequencer.sv
// Convolution loop-nest sequencer: walks j,k,i,m,n,l, flags padding
// taps and first taps, and emits a delayed save strobe per output.
// Ports: clk, reset, start, hold in; i,j,k,m,n,l, enable, pad_zero,
// acc_clear, en_save, save_i/j/k, busy, done out (all registered).
module conv_loop_sequencer
   import conv_loop_sequencer_pkg::*;
#(
   parameter int CONV_DIM_IMG    = 32,
   parameter int CONV_DIM_KERNEL = 5,
   parameter int CONV_DIM_CH     = 3,
   parameter int CONV_OUT_CH     = 32,
   parameter int CONV_DIM_OUT    = 32,
   parameter int STRIDE          = 1,
   parameter int PADDING         = 2,
   parameter int SAVE_DELAY      = 2
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
   input  logic            hold,
   output logic [BYTE-1:0] i,
   output logic [BYTE-1:0] j,
   output logic [BYTE-1:0] k,
   output logic [BYTE-1:0] m,
   output logic [BYTE-1:0] n,
   output logic [BYTE-1:0] l,
   output logic            enable,
   output logic            pad_zero,
   output logic            acc_clear,
   output logic            en_save,
   output logic [BYTE-1:0] save_i,
   output logic [BYTE-1:0] save_j,
   output logic [BYTE-1:0] save_k,
   output logic            busy,
   output logic            done
);

   localparam logic [BYTE-1:0] K_MAX  = BYTE'(CONV_DIM_KERNEL - 1);
   localparam logic [BYTE-1:0] CH_MAX = BYTE'(CONV_DIM_CH - 1);
   localparam logic [BYTE-1:0] OC_MAX = BYTE'(CONV_OUT_CH - 1);
   localparam logic [BYTE-1:0] DO_MAX = BYTE'(CONV_DIM_OUT - 1);
   localparam logic [3:0]      DR_MAX = 4'(SAVE_DELAY - 1);

   seq_state_t state_q, state_d;
   loop_idx_t  idx_q, idx_d, idx_nx;
   logic       enable_q, enable_d;
   logic       pad_q, pad_d;
   logic       acc_q, acc_d;
   logic       busy_q, busy_d;
   logic       done_q, done_d;
   logic [3:0] drain_q, drain_d;

   logic w_l, w_n, w_m, w_i, w_k, w_j;
   logic c_n, c_m, c_i, c_k, c_j;
   logic last_tap, final_tap;

   save_tag_t push_tag, head_tag;
   logic      head_vld;

   always_comb begin
      w_l = idx_q.l == CH_MAX;
      w_n = idx_q.n == K_MAX;
      w_m = idx_q.m == K_MAX;
      w_i = idx_q.i == OC_MAX;
      w_k = idx_q.k == DO_MAX;
      w_j = idx_q.j == DO_MAX;
      c_n = w_l;
      c_m = c_n & w_n;
      c_i = c_m & w_m;
      c_k = c_i & w_i;
      c_j = c_k & w_k;
   end

   // Tap index successor, l innermost, carrying outward to j.
   always_comb begin
      idx_nx   = idx_q;
      idx_nx.l = w_l ? '0 : idx_q.l + 1'b1;
      if (c_n) idx_nx.n = w_n ? '0 : idx_q.n + 1'b1;
      if (c_m) idx_nx.m = w_m ? '0 : idx_q.m + 1'b1;
      if (c_i) idx_nx.i = w_i ? '0 : idx_q.i + 1'b1;
      if (c_k) idx_nx.k = w_k ? '0 : idx_q.k + 1'b1;
      if (c_j) idx_nx.j = w_j ? '0 : idx_q.j + 1'b1;
   end

   assign last_tap  = enable_q & c_i & w_m;
   assign final_tap = last_tap & c_j & w_j;

   // A displayed tuple in RUN has always been issued already
   // (a stall freezes an issued tuple), so un-held cycles advance.
   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      enable_d = 1'b0;
      busy_d   = busy_q;
      done_d   = 1'b0;
      drain_d  = drain_q;
      unique case (state_q)
         SEQ_IDLE: begin
            if (start) begin
               state_d  = SEQ_RUN;
               idx_d    = '0;
               enable_d = 1'b1;
               busy_d   = 1'b1;
            end
         end
         SEQ_RUN: begin
            busy_d = 1'b1;
            if (final_tap) begin
               state_d = SEQ_DRAIN;
               drain_d = '0;
            end else if (!hold) begin
               idx_d    = idx_nx;
               enable_d = 1'b1;
            end
         end
         SEQ_DRAIN: begin
            if (drain_q == DR_MAX) begin
               state_d = SEQ_DONE;
               busy_d  = 1'b0;
               done_d  = 1'b1;
            end else begin
               drain_d = drain_q + 1'b1;
            end
         end
         SEQ_DONE: begin
            state_d = SEQ_IDLE;
            busy_d  = 1'b0;
            idx_d   = '0;
         end
         default: begin
            state_d = SEQ_IDLE;
         end
      endcase
   end

   always_comb begin
      pad_d = enable_d & tap_in_pad(idx_d.j, idx_d.k,
                                    idx_d.m, idx_d.n,
                                    STRIDE, PADDING,
                                    CONV_DIM_IMG);
      acc_d = enable_d & (idx_d.m == '0) &
              (idx_d.n == '0) & (idx_d.l == '0);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= SEQ_IDLE;
         idx_q    <= '0;
         enable_q <= 1'b0;
         pad_q    <= 1'b0;
         acc_q    <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         drain_q  <= '0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         enable_q <= enable_d;
         pad_q    <= pad_d;
         acc_q    <= acc_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         drain_q  <= drain_d;
      end
   end

   assign push_tag = '{i: idx_q.i, j: idx_q.j, k: idx_q.k};

   save_delay_line #(
      .DEPTH (SAVE_DELAY),
      .WIDTH ($bits(save_tag_t))
   ) u_save_dl (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (last_tap),
      .in_data   (push_tag),
      .out_valid (head_vld),
      .out_data  (head_tag)
   );

   assign i         = idx_q.i;
   assign j         = idx_q.j;
   assign k         = idx_q.k;
   assign m         = idx_q.m;
   assign n         = idx_q.n;
   assign l         = idx_q.l;
   assign enable    = enable_q;
   assign pad_zero  = pad_q;
   assign acc_clear = acc_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign en_save   = head_vld;
   assign save_i    = head_tag.i;
   assign save_j    = head_tag.j;
   assign save_k    = head_tag.k;

endmodule

// File: tb/tb_conv_loop_sequencer.sv
// Testbench for conv_loop_sequencer: randomized hold/start stimulus
// checked against a loop-nest reference model built in the bench.
module tb_conv_loop_sequencer;

   localparam int DIM_IMG = 4;
   localparam int KER     = 3;
   localparam int CH      = 1;
   localparam int OC      = 2;
   localparam int DOUT    = 4;
   localparam int STR     = 1;
   localparam int PAD     = 1;
   localparam int SD      = 2;
   localparam int TPO     = KER * KER * CH;
   localparam int NTAP    = DOUT * DOUT * OC * TPO;
   localparam int NSAVE   = DOUT * DOUT * OC;
   localparam int LIMIT   = 3000;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       start = 1'b0;
   logic       hold = 1'b0;
   logic [7:0] i, j, k, m, n, l;
   logic [7:0] save_i, save_j, save_k;
   logic       enable, pad_zero, acc_clear, en_save, busy, done;

   conv_loop_sequencer #(
      .CONV_DIM_IMG    (DIM_IMG),
      .CONV_DIM_KERNEL (KER),
      .CONV_DIM_CH     (CH),
      .CONV_OUT_CH     (OC),
      .CONV_DIM_OUT    (DOUT),
      .STRIDE          (STR),
      .PADDING         (PAD),
      .SAVE_DELAY      (SD)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .hold      (hold),
      .i         (i),
      .j         (j),
      .k         (k),
      .m         (m),
      .n         (n),
      .l         (l),
      .enable    (enable),
      .pad_zero  (pad_zero),
      .acc_clear (acc_clear),
      .en_save   (en_save),
      .save_i    (save_i),
      .save_j    (save_j),
      .save_k    (save_k),
      .busy      (busy),
      .done      (done)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   typedef struct {
      int i, j, k, m, n, l;
      bit pad;
      bit acc;
   } tap_t;

   int   checks = 0;
   int   failures = 0;
   tap_t exp_taps[$];
   tap_t obs_taps[$];
   int   obs_en_cyc[$];
   int   sv_i[$], sv_j[$], sv_k[$], sv_cyc[$];
   int   done_cyc, done_cnt, busy_bad, svhold_bad;
   int   gated_bad, froze_bad, frozen_seen;

   // Reference: plain loop nest in the documented order.
   task automatic build_model();
      tap_t t;
      int   row, col;
      exp_taps.delete();
      for (int jj = 0; jj < DOUT; jj++)
      for (int kk = 0; kk < DOUT; kk++)
      for (int ii = 0; ii < OC; ii++)
      for (int mm = 0; mm < KER; mm++)
      for (int nn = 0; nn < KER; nn++)
      for (int ll = 0; ll < CH; ll++) begin
         row = STR * jj + mm - PAD;
         col = STR * kk + nn - PAD;
         t.i = ii; t.j = jj; t.k = kk;
         t.m = mm; t.n = nn; t.l = ll;
         t.pad = (row < 0) || (row >= DIM_IMG) ||
                 (col < 0) || (col >= DIM_IMG);
         t.acc = (mm == 0) && (nn == 0) && (ll == 0);
         exp_taps.push_back(t);
      end
   endtask

   function automatic int tap_mismatches();
      int mm = 0;
      for (int t = 0; t < obs_taps.size(); t++) begin
         if (t >= exp_taps.size()) begin
            mm++;
         end else if (obs_taps[t].i != exp_taps[t].i ||
                      obs_taps[t].j != exp_taps[t].j ||
                      obs_taps[t].k != exp_taps[t].k ||
                      obs_taps[t].m != exp_taps[t].m ||
                      obs_taps[t].n != exp_taps[t].n ||
                      obs_taps[t].l != exp_taps[t].l ||
                      obs_taps[t].pad != exp_taps[t].pad ||
                      obs_taps[t].acc != exp_taps[t].acc) begin
            mm++;
         end
      end
      return mm;
   endfunction

   // Save s belongs to the last tap of output s, SD cycles later.
   function automatic int save_mismatches();
      int mm = 0;
      int idx;
      for (int s = 0; s < sv_cyc.size(); s++) begin
         idx = s * TPO + TPO - 1;
         if (idx >= exp_taps.size() || idx >= obs_en_cyc.size()) begin
            mm++;
         end else if (sv_i[s] != exp_taps[idx].i ||
                      sv_j[s] != exp_taps[idx].j ||
                      sv_k[s] != exp_taps[idx].k ||
                      sv_cyc[s] != obs_en_cyc[idx] + SD) begin
            mm++;
         end
      end
      return mm;
   endfunction

   function automatic int find_tap(int fj, int fk, int fm, int fn);
      for (int t = 0; t < obs_taps.size(); t++) begin
         if (obs_taps[t].j == fj && obs_taps[t].k == fk &&
             obs_taps[t].m == fm && obs_taps[t].n == fn &&
             obs_taps[t].i == 0 && obs_taps[t].l == 0)
            return t;
      end
      return -1;
   endfunction

   // mode 0: no stall, 1: one 3-cycle hold at first m=1,n=0,
   // 2: random holds, 3: random start pulses while busy.
   task automatic run_layer(input int mode);
      tap_t t;
      tap_t frozen;
      int   hold_left;
      bit   hold_used;
      bit   exp_frozen;
      int   li, lj, lk;
      obs_taps.delete();
      obs_en_cyc.delete();
      sv_i.delete(); sv_j.delete(); sv_k.delete(); sv_cyc.delete();
      done_cyc = -1; done_cnt = 0; busy_bad = 0; svhold_bad = 0;
      gated_bad = 0; froze_bad = 0; frozen_seen = 0;
      hold_left = 0; hold_used = 0; exp_frozen = 0;
      li = 0; lj = 0; lk = 0;
      frozen = '{default: 0};
      @(negedge clk);
      start = 1'b1;
      hold  = 1'b0;
      @(negedge clk);
      start = 1'b0;
      for (int c = 0; c < LIMIT; c++) begin
         if (c > 0) @(negedge clk);
         if (exp_frozen) begin
            frozen_seen++;
            if (enable !== 1'b0 || i != frozen.i || j != frozen.j ||
                k != frozen.k || m != frozen.m || n != frozen.n ||
                l != frozen.l)
               froze_bad++;
         end
         if (enable === 1'b1) begin
            t.i = int'(i); t.j = int'(j); t.k = int'(k);
            t.m = int'(m); t.n = int'(n); t.l = int'(l);
            t.pad = pad_zero;
            t.acc = acc_clear;
            obs_taps.push_back(t);
            obs_en_cyc.push_back(c);
         end else if (pad_zero !== 1'b0 || acc_clear !== 1'b0) begin
            gated_bad++;
         end
         if (en_save === 1'b1) begin
            li = int'(save_i); lj = int'(save_j); lk = int'(save_k);
            sv_i.push_back(li); sv_j.push_back(lj); sv_k.push_back(lk);
            sv_cyc.push_back(c);
         end else if (sv_cyc.size() > 0 &&
                      (int'(save_i) != li || int'(save_j) != lj ||
                       int'(save_k) != lk)) begin
            svhold_bad++;
         end
         if (done === 1'b1) begin
            done_cnt++;
            if (done_cyc < 0) done_cyc = c;
            if (busy !== 1'b0) busy_bad++;
         end else if (done_cyc < 0) begin
            if (busy !== 1'b1) busy_bad++;
         end else if (busy !== 1'b0) begin
            busy_bad++;
         end
         if (done_cyc >= 0 && c >= done_cyc + 4) break;
         hold = 1'b0;
         start = 1'b0;
         exp_frozen = 1'b0;
         if (mode == 1) begin
            if (!hold_used && enable === 1'b1 && m == 1 && n == 0) begin
               hold_used = 1'b1;
               hold_left = 3;
               frozen = t;
            end
            if (hold_left > 0) begin
               hold = 1'b1;
               hold_left--;
               exp_frozen = 1'b1;
            end
         end else if (mode == 2 && done_cyc < 0) begin
            hold = ($urandom_range(0, 3) == 0);
         end else if (mode == 3 && done_cyc < 0 && done !== 1'b1) begin
            start = ($urandom_range(0, 5) == 0);
         end
      end
      hold = 1'b0;
      start = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      start = 1'b0;
      hold  = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if ({i, j, k, m, n, l, save_i, save_j, save_k} !== 72'h0) begin
         failures++;
         $display("FAIL reset_indices got=%h want=0",
                  {i, j, k, m, n, l, save_i, save_j, save_k});
      end
      checks++;
      if ({enable, pad_zero, acc_clear, en_save, busy, done} !== 6'b0) begin
         failures++;
         $display("FAIL reset_strobes got=%b want=000000",
                  {enable, pad_zero, acc_clear, en_save, busy, done});
      end
      reset = 1'b0;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      checks++;
      if ({enable, acc_clear, pad_zero, busy} !== 4'b1111) begin
         failures++;
         $display("FAIL first_tap_strobes got=%b want=1111",
                  {enable, acc_clear, pad_zero, busy});
      end
      checks++;
      if ({i, j, k, m, n, l} !== 48'h0) begin
         failures++;
         $display("FAIL first_tap_indices got=%h want=0",
                  {i, j, k, m, n, l});
      end
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_full_run();
      run_layer(0);
      checks++;
      if (obs_taps.size() != NTAP) begin
         failures++;
         $display("FAIL full_enable_count got=%0d want=%0d",
                  obs_taps.size(), NTAP);
      end
      checks++;
      if (tap_mismatches() != 0) begin
         failures++;
         $display("FAIL full_tap_sequence got=%0d bad want=0",
                  tap_mismatches());
      end
      checks++;
      if (sv_cyc.size() != NSAVE) begin
         failures++;
         $display("FAIL full_save_count got=%0d want=%0d",
                  sv_cyc.size(), NSAVE);
      end
      checks++;
      if (done_cyc != NTAP - 1 + SD + 1 || done_cnt != 1) begin
         failures++;
         $display("FAIL full_done got=cyc%0d/x%0d want=cyc%0d/x1",
                  done_cyc, done_cnt, NTAP + SD);
      end
      checks++;
      if (busy_bad != 0 || gated_bad != 0 || svhold_bad != 0) begin
         failures++;
         $display("FAIL full_busy_gate_hold got=%0d/%0d/%0d want=0/0/0",
                  busy_bad, gated_bad, svhold_bad);
      end
   endtask

   task automatic test_padding();
      int pj[4]  = '{0, 0, 3, 1};
      int pk[4]  = '{0, 0, 1, 1};
      int pm[4]  = '{1, 0, 2, 0};
      int pn[4]  = '{1, 1, 1, 0};
      bit pz[4]  = '{1'b0, 1'b1, 1'b1, 1'b0};
      int idx;
      run_layer(0);
      for (int q = 0; q < 4; q++) begin
         idx = find_tap(pj[q], pk[q], pm[q], pn[q]);
         checks++;
         if (idx < 0) begin
            failures++;
            $display("FAIL pad_tap%0d got=missing want=present", q);
         end else if (obs_taps[idx].pad != pz[q]) begin
            failures++;
            $display("FAIL pad_tap%0d got=%0d want=%0d",
                     q, obs_taps[idx].pad, pz[q]);
         end
      end
   endtask

   task automatic test_save_order();
      run_layer(0);
      checks++;
      if (sv_cyc.size() < 3 || obs_en_cyc.size() < TPO) begin
         failures++;
         $display("FAIL save_first got=%0d saves want>=3", sv_cyc.size());
      end else begin
         if (sv_cyc[0] != obs_en_cyc[TPO-1] + SD ||
             sv_i[0] != 0 || sv_j[0] != 0 || sv_k[0] != 0) begin
            failures++;
            $display("FAIL save_first got=cyc%0d %0d/%0d/%0d want=cyc%0d 0/0/0",
                     sv_cyc[0], sv_i[0], sv_j[0], sv_k[0],
                     obs_en_cyc[TPO-1] + SD);
         end
         checks++;
         if (sv_i[1] != 1 || sv_j[1] != 0 || sv_k[1] != 0) begin
            failures++;
            $display("FAIL save_second got=%0d/%0d/%0d want=1/0/0",
                     sv_i[1], sv_j[1], sv_k[1]);
         end
         checks++;
         if (sv_i[2] != 0 || sv_j[2] != 0 || sv_k[2] != 1) begin
            failures++;
            $display("FAIL save_third got=%0d/%0d/%0d want=0/0/1",
                     sv_i[2], sv_j[2], sv_k[2]);
         end
      end
      checks++;
      if (save_mismatches() != 0) begin
         failures++;
         $display("FAIL save_all got=%0d bad want=0", save_mismatches());
      end
   endtask

   task automatic test_hold();
      run_layer(1);
      checks++;
      if (frozen_seen != 3 || froze_bad != 0) begin
         failures++;
         $display("FAIL hold_frozen got=%0d seen/%0d bad want=3/0",
                  frozen_seen, froze_bad);
      end
      checks++;
      if (obs_taps.size() != NTAP || tap_mismatches() != 0) begin
         failures++;
         $display("FAIL hold_taps got=%0d/%0d bad want=%0d/0",
                  obs_taps.size(), tap_mismatches(), NTAP);
      end
      checks++;
      if (sv_cyc.size() != NSAVE || save_mismatches() != 0) begin
         failures++;
         $display("FAIL hold_saves got=%0d/%0d bad want=%0d/0",
                  sv_cyc.size(), save_mismatches(), NSAVE);
      end
      checks++;
      if (done_cyc != NTAP + SD + 3 || done_cnt != 1) begin
         failures++;
         $display("FAIL hold_done got=cyc%0d/x%0d want=cyc%0d/x1",
                  done_cyc, done_cnt, NTAP + SD + 3);
      end
   endtask

   task automatic test_random_hold();
      for (int r = 0; r < 2; r++) begin
         run_layer(2);
         checks++;
         if (obs_taps.size() != NTAP || tap_mismatches() != 0) begin
            failures++;
            $display("FAIL rhold%0d_taps got=%0d/%0d bad want=%0d/0",
                     r, obs_taps.size(), tap_mismatches(), NTAP);
         end
         checks++;
         if (sv_cyc.size() != NSAVE || save_mismatches() != 0) begin
            failures++;
            $display("FAIL rhold%0d_saves got=%0d/%0d bad want=%0d/0",
                     r, sv_cyc.size(), save_mismatches(), NSAVE);
         end
         checks++;
         if (obs_en_cyc.size() == 0 ||
             done_cyc != obs_en_cyc[obs_en_cyc.size()-1] + SD + 1 ||
             done_cnt != 1 || gated_bad != 0 || busy_bad != 0) begin
            failures++;
            $display("FAIL rhold%0d_done got=cyc%0d x%0d gate%0d busy%0d",
                     r, done_cyc, done_cnt, gated_bad, busy_bad);
         end
      end
   endtask

   task automatic test_start_while_busy();
      run_layer(3);
      checks++;
      if (obs_taps.size() != NTAP || tap_mismatches() != 0) begin
         failures++;
         $display("FAIL sbusy_taps got=%0d/%0d bad want=%0d/0",
                  obs_taps.size(), tap_mismatches(), NTAP);
      end
      checks++;
      if (done_cyc != NTAP + SD || done_cnt != 1 ||
          sv_cyc.size() != NSAVE) begin
         failures++;
         $display("FAIL sbusy_done got=cyc%0d x%0d saves%0d want=cyc%0d x1 %0d",
                  done_cyc, done_cnt, sv_cyc.size(), NTAP + SD, NSAVE);
      end
   endtask

   task automatic test_reset_mid_run();
      int  lasts;
      bit  found;
      int  bad;
      lasts = 0;
      found = 1'b0;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int c = 0; c < 200 && !found; c++) begin
         if (c > 0) @(negedge clk);
         if (enable === 1'b1 && m == KER - 1 && n == KER - 1 &&
             l == CH - 1)
            lasts++;
         if (lasts == 3) found = 1'b1;
      end
      checks++;
      if (!found) begin
         failures++;
         $display("FAIL midreset_wait got=%0d last taps want=3", lasts);
      end
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      checks++;
      if ({i, j, k, m, n, l, save_i, save_j, save_k} !== 72'h0 ||
          {enable, pad_zero, acc_clear, en_save, busy, done} !== 6'b0) begin
         failures++;
         $display("FAIL midreset_clear got=%h/%b want=0/000000",
                  {i, j, k, m, n, l, save_i, save_j, save_k},
                  {enable, pad_zero, acc_clear, en_save, busy, done});
      end
      bad = 0;
      repeat (6) begin
         @(negedge clk);
         if (enable !== 1'b0 || en_save !== 1'b0 ||
             busy !== 1'b0 || done !== 1'b0)
            bad++;
      end
      checks++;
      if (bad != 0) begin
         failures++;
         $display("FAIL midreset_quiet got=%0d active cycles want=0", bad);
      end
   endtask

   task automatic test_back_to_back();
      for (int r = 0; r < 2; r++) begin
         run_layer(0);
         checks++;
         if (obs_taps.size() != NTAP || tap_mismatches() != 0 ||
             obs_en_cyc.size() == 0 || obs_en_cyc[0] != 0) begin
            failures++;
            $display("FAIL b2b%0d_taps got=%0d/%0d bad want=%0d/0",
                     r, obs_taps.size(), tap_mismatches(), NTAP);
         end
         checks++;
         if (done_cyc != NTAP + SD || sv_cyc.size() != NSAVE) begin
            failures++;
            $display("FAIL b2b%0d_done got=cyc%0d saves%0d want=cyc%0d %0d",
                     r, done_cyc, sv_cyc.size(), NTAP + SD, NSAVE);
         end
      end
   endtask

   initial begin
      build_model();
      test_reset();
      test_full_run();
      test_padding();
      test_save_order();
      test_hold();
      test_random_hold();
      test_start_while_busy();
      test_reset_mid_run();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
